// File: rtl/ahb_master_req_ctrl.sv
// ahb_master_req_ctrl
//
// Master-side request controller. One instance sits between an AHB master and
// the per-slave arbiters. It decodes the address phase into a one-hot request,
// presents the master's priority, and stalls the master until the selected
// arbiter grants. It holds the request for the whole burst, then holds the
// response route through the final data phase. An address that decodes to no
// slave gets a two-cycle ERROR response.
//
// Ports
//   hclk        clock
//   hreset_n    asynchronous active-low reset
//   htrans      master transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   haddr       master address; slave index = haddr[ADDR_W-1 -: SEL_BITS]
//   hburst      master burst encoding (SINGLE, INCR, WRAP4 .. INCR16)
//   cfg_prior   priority for this master, latched when a transfer is accepted
//   hgrant_in   bit s = this master's grant from slave s's arbiter
//   hready_s    HREADY of the currently routed slave
//   hreq        one-hot request to the arbiters
//   hprior      priority presented with hreq
//   hready_m    HREADY returned to the master
//   hresp_err   ERROR response to the master
//   hroute      one-hot response-mux select, held through the last data phase

module ahb_master_req_ctrl #(
  parameter int unsigned SLAVE_NUM = 6,
  parameter int unsigned SEL_BITS  = 3,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned PRIOR_BIT = 2
) (
  input  logic                 hclk,
  input  logic                 hreset_n,
  input  logic [1:0]           htrans,
  input  logic [ADDR_W-1:0]    haddr,
  input  logic [2:0]           hburst,
  input  logic [PRIOR_BIT-1:0] cfg_prior,
  input  logic [SLAVE_NUM-1:0] hgrant_in,
  input  logic                 hready_s,
  output logic [SLAVE_NUM-1:0] hreq,
  output logic [PRIOR_BIT-1:0] hprior,
  output logic                 hready_m,
  output logic                 hresp_err,
  output logic [SLAVE_NUM-1:0] hroute
);

  localparam logic [1:0] HtransIdle   = 2'd0;
  localparam logic [1:0] HtransNonseq = 2'd2;
  localparam logic [1:0] HtransSeq    = 2'd3;

  localparam logic [2:0] HburstSingle = 3'd0;
  localparam logic [2:0] HburstIncr   = 3'd1;
  localparam logic [2:0] HburstWrap4  = 3'd2;
  localparam logic [2:0] HburstIncr4  = 3'd3;
  localparam logic [2:0] HburstWrap8  = 3'd4;
  localparam logic [2:0] HburstIncr8  = 3'd5;
  localparam logic [2:0] HburstWrap16 = 3'd6;
  localparam logic [2:0] HburstIncr16 = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StXfer,
    StDone,
    StErr1,
    StErr2
  } state_e;

  // Beat limit for a burst; zero marks an unbounded INCR burst.
  function automatic logic [4:0] burst_limit(input logic [2:0] burst);
    logic [4:0] lim;
    case (burst)
      HburstSingle:              lim = 5'd1;
      HburstIncr:                lim = 5'd0;
      HburstWrap4, HburstIncr4:  lim = 5'd4;
      HburstWrap8, HburstIncr8:  lim = 5'd8;
      HburstWrap16, HburstIncr16: lim = 5'd16;
      default:                   lim = 5'd1;
    endcase
    return lim;
  endfunction

  state_e                 state_q, state_d;
  logic [4:0]             count_q, count_d;
  logic [4:0]             limit_q, limit_d;
  logic [SEL_BITS-1:0]    target_q, target_d;
  logic [PRIOR_BIT-1:0]   hprior_q, hprior_d;
  logic [SLAVE_NUM-1:0]   hreq_q, hreq_d;
  logic [SLAVE_NUM-1:0]   hroute_q, hroute_d;
  logic                   hresp_err_q, hresp_err_d;

  logic [SEL_BITS-1:0]    sel_idx;
  logic                   sel_valid;
  logic                   is_nonseq;
  logic                   beat;
  logic                   incr_end;
  logic                   accept;
  logic [4:0]             count_inc;
  logic [SLAVE_NUM-1:0]   target_oh_q;
  logic [SLAVE_NUM-1:0]   target_oh_d;

  logic                   unused_addr;
  assign unused_addr = ^haddr[ADDR_W-SEL_BITS-1:0];

  assign sel_idx   = haddr[ADDR_W-1 -: SEL_BITS];
  assign sel_valid = (32'(sel_idx) < SLAVE_NUM);
  assign is_nonseq = (htrans == HtransNonseq);
  assign beat      = hready_s && (is_nonseq || (htrans == HtransSeq));
  // Count saturates rather than wrapping during long INCR bursts.
  assign count_inc = (count_q == 5'd31) ? count_q : count_q + 5'd1;
  // An INCR burst ends on IDLE, or on a NONSEQ that follows at least one beat
  // (the first NONSEQ in XFER is the burst's own opening beat).
  assign incr_end  = (limit_q == 5'd0) && hready_s &&
                     ((htrans == HtransIdle) || (is_nonseq && (count_q != 5'd0)));

  always_comb begin
    target_oh_q = '0;
    target_oh_d = '0;
    for (int unsigned s = 0; s < SLAVE_NUM; s++) begin
      target_oh_q[s] = (target_q == SEL_BITS'(s));
      target_oh_d[s] = (target_d == SEL_BITS'(s));
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    limit_d  = limit_q;
    target_d = target_q;
    hprior_d = hprior_q;
    accept   = 1'b0;

    unique case (state_q)
      StIdle: accept = is_nonseq;
      StReq: begin
        if (|(hgrant_in & target_oh_q)) state_d = StXfer;
      end
      StXfer: begin
        // Grant loss is deliberately ignored here: the request stays up.
        if (incr_end) begin
          state_d = StDone;
        end else if (beat) begin
          count_d = count_inc;
          if ((limit_q != 5'd0) && (count_inc == limit_q)) state_d = StDone;
        end
      end
      StDone: begin
        if (hready_s) begin
          if (is_nonseq) accept = 1'b1;
          else           state_d = StIdle;
        end
      end
      StErr1:  state_d = StErr2;
      StErr2:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      target_d = sel_idx;
      limit_d  = burst_limit(hburst);
      hprior_d = cfg_prior;
      count_d  = 5'd0;
      state_d  = sel_valid ? StReq : StErr1;
    end
  end

  // Registered outputs follow the state being entered.
  always_comb begin
    hreq_d      = '0;
    hroute_d    = '0;
    hresp_err_d = 1'b0;
    if ((state_d == StReq) || (state_d == StXfer))  hreq_d   = target_oh_d;
    if ((state_d == StXfer) || (state_d == StDone)) hroute_d = target_oh_d;
    if ((state_d == StErr1) || (state_d == StErr2)) hresp_err_d = 1'b1;
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q     <= StIdle;
      count_q     <= 5'd0;
      limit_q     <= 5'd0;
      target_q    <= '0;
      hprior_q    <= '0;
      hreq_q      <= '0;
      hroute_q    <= '0;
      hresp_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      limit_q     <= limit_d;
      target_q    <= target_d;
      hprior_q    <= hprior_d;
      hreq_q      <= hreq_d;
      hroute_q    <= hroute_d;
      hresp_err_q <= hresp_err_d;
    end
  end

  // Slave wait states must reach the master in the same cycle, so HREADY is a
  // pass-through mux steered by the registered state.
  always_comb begin
    hready_m = 1'b1;
    unique case (state_q)
      StReq, StErr1:  hready_m = 1'b0;
      StXfer, StDone: hready_m = hready_s;
      default:        hready_m = 1'b1;
    endcase
  end

  assign hreq      = hreq_q;
  assign hroute    = hroute_q;
  assign hprior    = hprior_q;
  assign hresp_err = hresp_err_q;

endmodule

// File: tb/tb_ahb_master_req_ctrl.sv
// Directed testbench for ahb_master_req_ctrl. Each task applies a per-cycle
// table of inputs and compares the packed outputs
// {hreq, hroute, hprior, hready_m, hresp_err} against hand-derived values.

module tb_ahb_master_req_ctrl;

  localparam logic [1:0] TrI = 2'd0;
  localparam logic [1:0] TrB = 2'd1;
  localparam logic [1:0] TrN = 2'd2;
  localparam logic [1:0] TrS = 2'd3;

  localparam logic [2:0] BSingle = 3'd0;
  localparam logic [2:0] BIncr   = 3'd1;
  localparam logic [2:0] BIncr4  = 3'd3;
  localparam logic [2:0] BIncr16 = 3'd7;

  logic        hclk;
  logic        hreset_n;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [2:0]  hburst;
  logic [1:0]  cfg_prior;
  logic [5:0]  hgrant_in;
  logic        hready_s;
  logic [5:0]  hreq;
  logic [1:0]  hprior;
  logic        hready_m;
  logic        hresp_err;
  logic [5:0]  hroute;
  logic [15:0] obs;

  int checks = 0;
  int errors = 0;

  ahb_master_req_ctrl #(
    .SLAVE_NUM(6),
    .SEL_BITS (3),
    .ADDR_W   (32),
    .PRIOR_BIT(2)
  ) dut (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .htrans   (htrans),
    .haddr    (haddr),
    .hburst   (hburst),
    .cfg_prior(cfg_prior),
    .hgrant_in(hgrant_in),
    .hready_s (hready_s),
    .hreq     (hreq),
    .hprior   (hprior),
    .hready_m (hready_m),
    .hresp_err(hresp_err),
    .hroute   (hroute)
  );

  assign obs = {hreq, hroute, hprior, hready_m, hresp_err};

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  function automatic logic [15:0] ex_pk(input logic [5:0] q, input logic [5:0] r,
                                        input logic [1:0] p, input logic m, input logic e);
    return {q, r, p, m, e};
  endfunction

  task automatic test_reset();
    hreset_n = 1'b1;
    #2 hreset_n = 1'b0;
    #1;
    checks++;
    if (obs !== ex_pk(6'd0, 6'd0, 2'b00, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL reset_async obs=%b exp=%b", obs, ex_pk(6'd0, 6'd0, 2'b00, 1'b1, 1'b0));
    end
    repeat (2) @(posedge hclk);
    @(negedge hclk) hreset_n = 1'b1;
    @(posedge hclk); #1;
    checks++;
    if (obs !== ex_pk(6'd0, 6'd0, 2'b00, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL reset_release obs=%b exp=%b", obs, ex_pk(6'd0, 6'd0, 2'b00, 1'b1, 1'b0));
    end
  endtask

  // SINGLE to slave 2, grant one cycle after the request.
  task automatic test_single();
    logic [1:0]  tr [5];
    logic        rd [5];
    logic [5:0]  gn [5];
    logic [15:0] ex [5];
    tr = '{TrN, TrN, TrN, TrI, TrI};
    rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    gn = '{6'd0, 6'b000100, 6'b000100, 6'b000100, 6'd0};
    ex = '{ex_pk(6'd0,      6'd0,      2'b00, 1'b1, 1'b0),
           ex_pk(6'b000100, 6'd0,      2'b01, 1'b0, 1'b0),
           ex_pk(6'b000100, 6'b000100, 2'b01, 1'b1, 1'b0),
           ex_pk(6'd0,      6'b000100, 2'b01, 1'b1, 1'b0),
           ex_pk(6'd0,      6'd0,      2'b01, 1'b1, 1'b0)};
    haddr = 32'h4000_0000; hburst = BSingle; cfg_prior = 2'b01;
    for (int i = 0; i < 5; i++) begin
      htrans = tr[i]; hready_s = rd[i]; hgrant_in = gn[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL single c%0d obs=%b exp=%b", i, obs, ex[i]);
      end
      @(posedge hclk); #1;
    end
    htrans = TrI;
  endtask

  // INCR4 to slave 5 with a two-cycle wait on beat 2 and a grant drop mid-burst.
  task automatic test_incr4_wait();
    logic [1:0]  tr [10];
    logic        rd [10];
    logic [5:0]  gn [10];
    logic [15:0] ex [10];
    logic [5:0]  h;
    h  = 6'b100000;
    tr = '{TrN, TrN, TrN, TrS, TrS, TrS, TrS, TrS, TrI, TrI};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    gn = '{6'd0, h, h, h, h, h, 6'd0, h, 6'd0, 6'd0};
    ex = '{ex_pk(6'd0, 6'd0, 2'b01, 1'b1, 1'b0),
           ex_pk(h,    6'd0, 2'b11, 1'b0, 1'b0),
           ex_pk(h,    h,    2'b11, 1'b1, 1'b0),
           ex_pk(h,    h,    2'b11, 1'b0, 1'b0),
           ex_pk(h,    h,    2'b11, 1'b0, 1'b0),
           ex_pk(h,    h,    2'b11, 1'b1, 1'b0),
           ex_pk(h,    h,    2'b11, 1'b1, 1'b0),
           ex_pk(h,    h,    2'b11, 1'b1, 1'b0),
           ex_pk(6'd0, h,    2'b11, 1'b1, 1'b0),
           ex_pk(6'd0, 6'd0, 2'b11, 1'b1, 1'b0)};
    haddr = 32'hA000_0000; hburst = BIncr4; cfg_prior = 2'b11;
    for (int i = 0; i < 10; i++) begin
      htrans = tr[i]; hready_s = rd[i]; hgrant_in = gn[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL incr4_wait c%0d obs=%b exp=%b", i, obs, ex[i]);
      end
      @(posedge hclk); #1;
    end
    htrans = TrI;
  endtask

  // Six-beat INCR to slave 0 with one BUSY, terminated by IDLE.
  task automatic test_incr_term();
    logic [1:0]  tr [12];
    logic [5:0]  gn [12];
    logic [15:0] ex [12];
    logic [5:0]  h;
    h  = 6'b000001;
    tr = '{TrN, TrN, TrN, TrS, TrB, TrS, TrS, TrS, TrS, TrI, TrI, TrI};
    for (int i = 0; i < 12; i++) begin
      gn[i] = (i >= 1 && i <= 9) ? h : 6'd0;
      ex[i] = ex_pk(h, h, 2'b10, 1'b1, 1'b0);
    end
    ex[0]  = ex_pk(6'd0, 6'd0, 2'b11, 1'b1, 1'b0);
    ex[1]  = ex_pk(h,    6'd0, 2'b10, 1'b0, 1'b0);
    ex[10] = ex_pk(6'd0, h,    2'b10, 1'b1, 1'b0);
    ex[11] = ex_pk(6'd0, 6'd0, 2'b10, 1'b1, 1'b0);
    haddr = 32'h0000_1000; hburst = BIncr; cfg_prior = 2'b10;
    for (int i = 0; i < 12; i++) begin
      htrans = tr[i]; hready_s = 1'b1; hgrant_in = gn[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL incr_term c%0d obs=%b exp=%b", i, obs, ex[i]);
      end
      @(posedge hclk); #1;
    end
    htrans = TrI;
  endtask

  // Address decoding to slave 7 (no such slave): two-cycle ERROR.
  task automatic test_decode_err();
    logic [1:0]  tr [4];
    logic [15:0] ex [4];
    tr = '{TrN, TrI, TrI, TrI};
    ex = '{ex_pk(6'd0, 6'd0, 2'b10, 1'b1, 1'b0),
           ex_pk(6'd0, 6'd0, 2'b10, 1'b0, 1'b1),
           ex_pk(6'd0, 6'd0, 2'b10, 1'b1, 1'b1),
           ex_pk(6'd0, 6'd0, 2'b10, 1'b1, 1'b0)};
    haddr = 32'hE000_0000; hburst = BSingle; cfg_prior = 2'b10;
    for (int i = 0; i < 4; i++) begin
      htrans = tr[i]; hready_s = 1'b1; hgrant_in = 6'd0;
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL decode_err c%0d obs=%b exp=%b", i, obs, ex[i]);
      end
      @(posedge hclk); #1;
    end
    htrans = TrI;
  endtask

  // SINGLE to slave 1, then a NONSEQ to slave 3 accepted in DONE; the second
  // DONE is stretched by one wait state.
  task automatic test_back_to_back();
    logic [1:0]  tr [9];
    logic        rd [9];
    logic [5:0]  gn [9];
    logic [15:0] ex [9];
    logic [5:0]  a;
    logic [5:0]  b;
    a  = 6'b000010;
    b  = 6'b001000;
    tr = '{TrN, TrN, TrN, TrN, TrN, TrN, TrI, TrI, TrI};
    rd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    gn = '{6'd0, a, a, 6'd0, b, b, 6'd0, 6'd0, 6'd0};
    ex = '{ex_pk(6'd0, 6'd0, 2'b10, 1'b1, 1'b0),
           ex_pk(a,    6'd0, 2'b01, 1'b0, 1'b0),
           ex_pk(a,    a,    2'b01, 1'b1, 1'b0),
           ex_pk(6'd0, a,    2'b01, 1'b1, 1'b0),
           ex_pk(b,    6'd0, 2'b00, 1'b0, 1'b0),
           ex_pk(b,    b,    2'b00, 1'b1, 1'b0),
           ex_pk(6'd0, b,    2'b00, 1'b0, 1'b0),
           ex_pk(6'd0, b,    2'b00, 1'b1, 1'b0),
           ex_pk(6'd0, 6'd0, 2'b00, 1'b1, 1'b0)};
    hburst = BSingle; cfg_prior = 2'b01;
    for (int i = 0; i < 9; i++) begin
      haddr = (i >= 3) ? 32'h6000_0000 : 32'h2000_0000;
      if (i == 3) cfg_prior = 2'b00;
      htrans = tr[i]; hready_s = rd[i]; hgrant_in = gn[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL back_to_back c%0d obs=%b exp=%b", i, obs, ex[i]);
      end
      @(posedge hclk); #1;
    end
    htrans = TrI;
  endtask

  // INCR16 to slave 4 interrupted by reset after nine beats.
  task automatic test_reset_mid_burst();
    logic [15:0] ex [11];
    logic [5:0]  h;
    h = 6'b010000;
    for (int i = 0; i < 11; i++) ex[i] = ex_pk(h, h, 2'b01, 1'b1, 1'b0);
    ex[0] = ex_pk(6'd0, 6'd0, 2'b00, 1'b1, 1'b0);
    ex[1] = ex_pk(h,    6'd0, 2'b01, 1'b0, 1'b0);
    haddr = 32'h8000_0000; hburst = BIncr16; cfg_prior = 2'b01;
    for (int i = 0; i < 11; i++) begin
      htrans = (i <= 2) ? TrN : TrS; hready_s = 1'b1;
      hgrant_in = (i >= 1) ? h : 6'd0;
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL reset_mid c%0d obs=%b exp=%b", i, obs, ex[i]);
      end
      @(posedge hclk); #1;
    end
    hreset_n = 1'b0;
    #1;
    checks++;
    if (obs !== ex_pk(6'd0, 6'd0, 2'b00, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL reset_mid_async obs=%b exp=%b", obs, ex_pk(6'd0, 6'd0, 2'b00, 1'b1, 1'b0));
    end
    @(posedge hclk); #1;
    checks++;
    if (obs !== ex_pk(6'd0, 6'd0, 2'b00, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL reset_mid_hold obs=%b exp=%b", obs, ex_pk(6'd0, 6'd0, 2'b00, 1'b1, 1'b0));
    end
    htrans = TrI; hgrant_in = 6'd0;
    hreset_n = 1'b1;
    @(posedge hclk); #1;
  endtask

  // Full INCR16 after reset: the 16th beat is the last one held in XFER.
  task automatic test_incr16_full();
    logic [15:0] ex [20];
    logic [5:0]  h;
    h = 6'b010000;
    for (int i = 0; i < 20; i++) ex[i] = ex_pk(h, h, 2'b11, 1'b1, 1'b0);
    ex[0]  = ex_pk(6'd0, 6'd0, 2'b00, 1'b1, 1'b0);
    ex[1]  = ex_pk(h,    6'd0, 2'b11, 1'b0, 1'b0);
    ex[18] = ex_pk(6'd0, h,    2'b11, 1'b1, 1'b0);
    ex[19] = ex_pk(6'd0, 6'd0, 2'b11, 1'b1, 1'b0);
    haddr = 32'h8000_0000; hburst = BIncr16; cfg_prior = 2'b11;
    for (int i = 0; i < 20; i++) begin
      htrans = (i <= 2) ? TrN : ((i <= 17) ? TrS : TrI);
      hready_s = 1'b1;
      hgrant_in = (i >= 1 && i <= 17) ? h : 6'd0;
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++;
        $display("FAIL incr16_full c%0d obs=%b exp=%b", i, obs, ex[i]);
      end
      @(posedge hclk); #1;
    end
    htrans = TrI;
  endtask

  initial begin
    htrans    = TrI;
    haddr     = 32'h0;
    hburst    = BSingle;
    cfg_prior = 2'b00;
    hgrant_in = 6'd0;
    hready_s  = 1'b1;
    test_reset();
    test_single();
    test_incr4_wait();
    test_incr_term();
    test_decode_err();
    test_back_to_back();
    test_reset_mid_burst();
    test_incr16_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
